edge_detector_multi: RTL and testbench
======================================

Name: edge_detector_multi

Overview:
- Parametrised N-channel edge detector; successor to the single-bit rising-edge detector.
- Each channel has an input synchroniser, per-channel mode (off/rise/fall/both), a one-cycle event pulse, a sticky flag and a saturating event counter.
- Sits between asynchronous status/GPIO lines and control logic or CSR readback.

Parameters:
- N, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (1..4).
- CNT_W, 8, width of each per-channel event counter (>=2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- din  input  N  raw (possibly asynchronous) channel inputs.
- mode  input  2*N  per-channel mode, bits [2i+1:2i] for channel i. 00 off, 01 rise, 10 fall, 11 both.
- en  input  1  global detect enable.
- clr  input  N  per-channel clear of sticky flag and counter.
- pulse  output  N  one-cycle event strobe per channel.
- sticky  output  N  latched event flag per channel.
- cnt  output  N*CNT_W  per-channel event count, bits [CNT_W*(i+1)-1:CNT_W*i].
- any_evt  output  1  OR of pulse.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Sync flops, prev sample, pulse, sticky and cnt go to 0.
  - Priming counter goes to 0.
  - any_evt is therefore 0.
- Synchroniser: din[i] passes through SYNC_STAGES flops to give s[i]. A prev register holds s[i] from the previous cycle.
- Priming:
  - Detection is suppressed until SYNC_STAGES+1 clk edges after rst_n deasserts, i.e. until prev holds a genuinely sampled value.
  - A line held at 1 through reset therefore never reports a rising edge.
- Edge terms: rise = s & ~prev; fall = ~s & prev.
- Event per mode: evt[i] = (mode bit0 & rise) | (mode bit1 & fall), gated by en and primed.
- Latency: a din transition that meets setup before edge k gives pulse[i]=1 in the cycle after edge k+SYNC_STAGES. The pulse is exactly one cycle wide.
- Level not held: a din pulse shorter than one clk may be missed. Only transitions seen at s are counted.
- en=0:
  - pulse is 0; sticky and cnt hold.
  - The sync chain and prev keep updating, so a level change during en=0 is not reported on re-enable.
- sticky[i]: set on evt[i]; cleared by clr[i]. Simultaneous evt and clr leaves sticky=1 (set wins).
- cnt[i]:
  - Increments on evt[i] and saturates at 2^CNT_W-1, with no wrap.
  - clr[i] loads 0. Simultaneous clr and evt loads 1.
- Mode change mid-stream: takes effect on the next cycle's evt evaluation. No pipeline flush.
- Reset mid-operation: all state returns to reset values at that edge and priming restarts.
- any_evt is a combinational OR of the registered pulse, with no extra latency.

Decomposition:
- Package edge_det_pkg holds:
  - MODE_OFF=2'b00, MODE_RISE=2'b01, MODE_FALL=2'b10, MODE_BOTH=2'b11.
  - The SYNC_STAGES range limit.
- Sub-module edge_det_chan covers one channel: sync chain, prev, edge logic, pulse, sticky and counter. It takes primed and en as inputs.
- The top level holds the shared priming counter, a generate loop of N edge_det_chan instances, and the any_evt reduction.

Test Plan:
- Reset release: din=4'b1111 held through reset and after, all modes 11 → pulse=0 forever; sticky=0; cnt=0.
- N=4, SYNC_STAGES=2, ch0 mode 01, din[0] 0→1 before edge k → pulse[0]=1 only in the cycle after edge k+2; cnt[0]=1; sticky[0]=1; any_evt=1 for that one cycle.
- ch1 mode 10 then 11, din[1] toggled 1→0→1→0 → in mode 10 only falling edges pulse; in mode 11 every toggle pulses; cnt[1] equals the pulse count.
- CNT_W=4, 20 rising edges on ch2 → cnt[2]=15 after the 15th edge and stays at 15; clr[2] → cnt[2]=0, sticky[2]=0.
- clr[3] asserted in the same cycle as an event on ch3 → sticky[3]=1, cnt[3]=1.
- en=0 while din[0] goes 0→1, then en=1 with din steady → no pulse ever, cnt holds. rst_n=0 for one cycle mid-stream → all outputs 0 next cycle and priming is suppressed again for 3 edges.

Source files
------------

// File: rtl/edge_det_pkg.sv
// Shared definitions for the multi-channel edge detector: channel modes,
// synchroniser depth limits and the mode-to-event helper.
package edge_det_pkg;

  localparam int unsigned SYNC_STAGES_MIN = 1;
  localparam int unsigned SYNC_STAGES_MAX = 4;

  typedef enum logic [1:0] {
    MODE_OFF  = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } mode_e;

  function automatic logic mode_hit(input mode_e m, input logic rise, input logic fall);
    logic hit;
    hit = 1'b0;
    case (m)
      MODE_OFF:  hit = 1'b0;
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_det_chan.sv
// One edge-detector channel: input synchroniser, previous-sample register,
// mode-selected edge event, registered pulse, sticky flag and saturating counter.
module edge_det_chan
  import edge_det_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic             primed,
  input  logic             clr,
  output logic             pulse,
  output logic             sticky,
  output logic [CNT_W-1:0] cnt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   pulse_q, pulse_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic s;
  logic rise;
  logic fall;
  logic evt;

  always_comb begin
    // Shift din in at bit 0; the cast drops the oldest stage.
    sync_d = SYNC_STAGES'({sync_q, din});
    s      = sync_q[SYNC_STAGES-1];
    prev_d = s;

    rise = s & ~prev_q;
    fall = ~s & prev_q;
    evt  = en & primed & mode_hit(mode_e'(mode), rise, fall);

    pulse_d  = evt;
    sticky_d = evt | (sticky_q & ~clr);

    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = evt ? CNT_W'(1) : '0;
    end else if (evt && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      pulse_q  <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      pulse_q  <= pulse_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign pulse  = pulse_q;
  assign sticky = sticky_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/edge_detector_multi.sv
// N-channel edge detector: shared post-reset priming counter, one
// edge_det_chan per channel and an OR of all event pulses.
module edge_detector_multi
  import edge_det_pkg::*;
#(
  parameter int unsigned N           = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         din,
  input  logic [2*N-1:0]       mode,
  input  logic                 en,
  input  logic [N-1:0]         clr,
  output logic [N-1:0]         pulse,
  output logic [N-1:0]         sticky,
  output logic [N*CNT_W-1:0]   cnt,
  output logic                 any_evt
);

  localparam int unsigned PRIME_TGT = SYNC_STAGES + 1;
  localparam int unsigned PRIME_W   = $clog2(SYNC_STAGES + 2);

  if ((SYNC_STAGES < SYNC_STAGES_MIN) || (SYNC_STAGES > SYNC_STAGES_MAX)) begin : g_bad_sync
    $error("edge_detector_multi: SYNC_STAGES out of range");
  end

  logic [PRIME_W-1:0] prime_q, prime_d;
  logic               primed;

  // prev only holds a real sample once SYNC_STAGES+1 edges have passed.
  always_comb begin
    primed  = (prime_q == PRIME_W'(PRIME_TGT));
    prime_d = prime_q;
    if (!primed) begin
      prime_d = prime_q + PRIME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prime_q <= '0;
    end else begin
      prime_q <= prime_d;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    edge_det_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .din    (din[i]),
      .mode   (mode[2*i +: 2]),
      .en     (en),
      .primed (primed),
      .clr    (clr[i]),
      .pulse  (pulse[i]),
      .sticky (sticky[i]),
      .cnt    (cnt[CNT_W*i +: CNT_W])
    );
  end

  assign any_evt = |pulse;

endmodule

// File: tb/tb_edge_detector_multi.sv
// Directed plus randomized bench for edge_detector_multi, checked against a
// sample-history reference model of the edge/sticky/counter rules.
module tb_edge_detector_multi;

  localparam int N     = 4;
  localparam int S     = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [N-1:0]       din;
  logic [2*N-1:0]     mode;
  logic               en;
  logic [N-1:0]       clr;
  logic [N-1:0]       pulse;
  logic [N-1:0]       sticky;
  logic [N*CNT_W-1:0] cnt;
  logic               any_evt;

  edge_detector_multi #(
    .N           (N),
    .SYNC_STAGES (S),
    .CNT_W       (CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .mode    (mode),
    .en      (en),
    .clr     (clr),
    .pulse   (pulse),
    .sticky  (sticky),
    .cnt     (cnt),
    .any_evt (any_evt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: din samples taken at each edge since reset release.
  logic [N-1:0] hist[$];
  logic [N-1:0] exp_pulse;
  logic [N-1:0] exp_sticky;
  int           exp_cnt[N];

  function automatic logic [N*CNT_W-1:0] pack_cnt();
    logic [N*CNT_W-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[c*CNT_W +: CNT_W] = exp_cnt[c][CNT_W-1:0];
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: model consumes the inputs seen at the edge, then outputs are compared.
  task automatic step();
    int n;
    logic [N-1:0] cur_s, old_s;
    logic [1:0] md;
    logic r, f, e;
    @(posedge clk);
    if (!rst_n) begin
      hist.delete();
      exp_pulse  = '0;
      exp_sticky = '0;
      for (int c = 0; c < N; c++) exp_cnt[c] = 0;
    end else begin
      hist.push_back(din);
      n = hist.size();
      cur_s = '0;
      old_s = '0;
      if (n >= S + 2) begin
        cur_s = hist[n-S-1];
        old_s = hist[n-S-2];
      end
      for (int c = 0; c < N; c++) begin
        md = mode[2*c +: 2];
        r  = cur_s[c] & ~old_s[c];
        f  = ~cur_s[c] & old_s[c];
        e  = (n >= S + 2) && en && ((md[0] && r) || (md[1] && f));
        exp_pulse[c]  = e;
        exp_sticky[c] = e | (exp_sticky[c] & ~clr[c]);
        if (clr[c]) exp_cnt[c] = e ? 1 : 0;
        else if (e && exp_cnt[c] < CMAX) exp_cnt[c] = exp_cnt[c] + 1;
      end
    end
    #1;
    chk("pulse",   32'(pulse),   32'(exp_pulse));
    chk("sticky",  32'(sticky),  32'(exp_sticky));
    chk("cnt",     32'(cnt),     32'(pack_cnt()));
    chk("any_evt", 32'(any_evt), 32'(|exp_pulse));
  endtask

  int p0_seen;

  initial begin
    rst_n = 1'b0;
    din   = 4'hF;
    mode  = 8'hFF;
    en    = 1'b1;
    clr   = '0;

    // Lines held high through reset never report a rising edge.
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    chk("rst_pulse",  32'(pulse),  32'h0);
    chk("rst_sticky", 32'(sticky), 32'h0);
    chk("rst_cnt",    32'(cnt),    32'h0);

    // ch0 rise latency: pulse in the cycle after edge k+2.
    mode = 8'b11_01_10_01;
    din[0] = 1'b0;
    repeat (5) step();
    din[0] = 1'b1;
    step();
    chk("lat_k0", 32'(pulse[0]), 32'h0);
    step();
    chk("lat_k1", 32'(pulse[0]), 32'h0);
    step();
    chk("lat_k2",    32'(pulse[0]),  32'h1);
    chk("lat_any",   32'(any_evt),   32'h1);
    chk("lat_cnt0",  32'(cnt[3:0]),  32'h1);
    chk("lat_stk0",  32'(sticky[0]), 32'h1);
    step();
    chk("lat_k3", 32'(pulse[0]), 32'h0);

    // ch1: fall-only, then both.
    for (int t = 0; t < 4; t++) begin
      din[1] = ~din[1];
      repeat (4) step();
    end
    chk("fall_cnt1", 32'(cnt[7:4]), 32'h2);
    mode[3:2] = 2'b11;
    for (int t = 0; t < 4; t++) begin
      din[1] = ~din[1];
      repeat (4) step();
    end
    chk("both_cnt1", 32'(cnt[7:4]), 32'h6);

    // ch2: 20 rising edges saturate a 4-bit counter, then clear.
    for (int t = 0; t < 20; t++) begin
      din[2] = 1'b0;
      repeat (3) step();
      din[2] = 1'b1;
      repeat (3) step();
    end
    chk("sat_cnt2", 32'(cnt[11:8]), 32'hF);
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    chk("clr_cnt2", 32'(cnt[11:8]), 32'h0);
    chk("clr_stk2", 32'(sticky[2]), 32'h0);

    // ch3: clear coincident with an event.
    din[3] = 1'b0;
    repeat (2) step();
    clr[3] = 1'b1;
    step();
    clr[3] = 1'b0;
    chk("clrevt_pulse3", 32'(pulse[3]),   32'h1);
    chk("clrevt_stk3",   32'(sticky[3]),  32'h1);
    chk("clrevt_cnt3",   32'(cnt[15:12]), 32'h1);

    // Level change while disabled is not reported on re-enable.
    din[0] = 1'b0;
    repeat (5) step();
    p0_seen = 0;
    en = 1'b0;
    din[0] = 1'b1;
    for (int t = 0; t < 6; t++) begin step(); p0_seen += int'(pulse[0]); end
    en = 1'b1;
    for (int t = 0; t < 6; t++) begin step(); p0_seen += int'(pulse[0]); end
    chk("dis_pulses", 32'(p0_seen), 32'h0);
    chk("dis_cnt0",   32'(cnt[3:0]), 32'h1);

    // Randomized traffic.
    for (int t = 0; t < 400; t++) begin
      din  = 4'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 8'($urandom);
      en   = ($urandom_range(0, 7) != 0);
      for (int c = 0; c < N; c++) clr[c] = ($urandom_range(0, 15) == 0);
      step();
    end
    clr = '0;
    en  = 1'b1;

    // Mid-stream reset and re-priming.
    rst_n = 1'b0;
    step();
    chk("mrst_pulse",  32'(pulse),   32'h0);
    chk("mrst_sticky", 32'(sticky),  32'h0);
    chk("mrst_cnt",    32'(cnt),     32'h0);
    chk("mrst_any",    32'(any_evt), 32'h0);
    rst_n = 1'b1;
    mode  = 8'hFF;
    din   = 4'h5;
    for (int e = 1; e <= 4; e++) begin
      step();
      if (e <= 3) chk("prime_quiet", 32'(pulse), 32'h0);
      else        chk("prime_first", 32'(pulse), 32'hF);
      din = ~din;
    end
    for (int t = 0; t < 100; t++) begin
      din = 4'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
